// File: rtl/mmu_cpl_demux_pkg.sv
// Shared types for the host-DMA completion return path.
// The ordering entry layout matches what the host-DMA arbiter pushes.
package mmu_cpl_demux_pkg;

  localparam int unsigned MmuVfidBits = 2;
  localparam int unsigned MmuPidBits  = 6;
  localparam int unsigned MmuDestBits = 4;

  typedef struct packed {
    logic [MmuVfidBits-1:0] vfid;
    logic [MmuPidBits-1:0]  pid;
    logic [MmuDestBits-1:0] dest;
    logic                   last;
  } mmu_ord_entry_t;

  typedef enum logic {StIdle, StSend} cpl_state_e;

endpackage

// File: rtl/mmu_ord_fifo.sv
// Synchronous FIFO with full/empty flags and an occupancy count.
// The caller must only push when not full; pops on empty are ignored.
module mmu_ord_fifo #(
  parameter int unsigned Depth = 32,
  parameter int unsigned Width = 13,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: contents are only read once the pointers cover them.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmu_cpl_demux.sv
// Routes XDMA completion pulses back, in issue order, to the region that
// issued each request, as a per-region done/ack handshake.
module mmu_cpl_demux
  import mmu_cpl_demux_pkg::*;
#(
  parameter int unsigned N_REGIONS      = 4,
  parameter int unsigned N_REGIONS_BITS = MmuVfidBits,
  parameter int unsigned PID_BITS       = MmuPidBits,
  parameter int unsigned DEST_BITS      = MmuDestBits,
  parameter int unsigned ORD_DEPTH      = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_mux_valid,
  output logic                      s_mux_ready,
  input  logic [N_REGIONS_BITS-1:0] s_mux_vfid,
  input  logic [PID_BITS-1:0]       s_mux_pid,
  input  logic [DEST_BITS-1:0]      s_mux_dest,
  input  logic                      s_mux_last,
  input  logic                      s_dma_done,
  output logic [N_REGIONS-1:0]      m_done_valid,
  input  logic [N_REGIONS-1:0]      m_done_ready,
  output logic [PID_BITS-1:0]       m_done_pid,
  output logic [DEST_BITS-1:0]      m_done_dest,
  output logic                      cpl_err
);

  localparam int unsigned CntW = $clog2(ORD_DEPTH) + 1;

  mmu_ord_entry_t wdata, head;
  logic [$bits(mmu_ord_entry_t)-1:0] fifo_rdata;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            push, pop, pulse_ok;

  cpl_state_e                state_q, state_d;
  logic [CntW-1:0]           done_cnt_q, done_cnt_d;
  logic [N_REGIONS_BITS-1:0] vfid_q, vfid_d;
  logic [PID_BITS-1:0]       pid_q, pid_d;
  logic [DEST_BITS-1:0]      dest_q, dest_d;
  logic                      cpl_err_q, cpl_err_d;

  assign s_mux_ready = !fifo_full && !areset;
  assign push        = s_mux_valid && s_mux_ready;

  always_comb begin
    wdata.vfid = s_mux_vfid;
    wdata.pid  = s_mux_pid;
    wdata.dest = s_mux_dest;
    wdata.last = s_mux_last;
  end

  assign head = mmu_ord_entry_t'(fifo_rdata);

  mmu_ord_fifo #(
    .Depth (ORD_DEPTH),
    .Width ($bits(mmu_ord_entry_t))
  ) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A pulse is only meaningful while some queued entry still lacks its completion.
  assign pulse_ok = s_dma_done && (done_cnt_q != fifo_count);

  always_comb begin
    state_d = state_q;
    vfid_d  = vfid_q;
    pid_d   = pid_q;
    dest_d  = dest_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((done_cnt_q != '0) && !fifo_empty) begin
          pop = 1'b1;
          if (head.last) begin
            vfid_d  = head.vfid;
            pid_d   = head.pid;
            dest_d  = head.dest;
            state_d = StSend;
          end
        end
      end
      StSend: begin
        if (m_done_ready[vfid_q]) state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (pulse_ok && !pop) begin
      done_cnt_d = done_cnt_q + CntW'(1);
    end else if (!pulse_ok && pop) begin
      done_cnt_d = done_cnt_q - CntW'(1);
    end
    cpl_err_d = cpl_err_q || (s_dma_done && !pulse_ok);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= StIdle;
      done_cnt_q <= '0;
      vfid_q     <= '0;
      pid_q      <= '0;
      dest_q     <= '0;
      cpl_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_cnt_q <= done_cnt_d;
      vfid_q     <= vfid_d;
      pid_q      <= pid_d;
      dest_q     <= dest_d;
      cpl_err_q  <= cpl_err_d;
    end
  end

  always_comb begin
    m_done_valid = '0;
    if (state_q == StSend) m_done_valid[vfid_q] = 1'b1;
  end

  assign m_done_pid  = pid_q;
  assign m_done_dest = dest_q;
  assign cpl_err     = cpl_err_q;

endmodule

// File: tb/tb_mmu_cpl_demux.sv
// Directed bench for mmu_cpl_demux: ordering, silent consumes, head-of-line
// blocking, FIFO full, spurious completions and mid-flight reset.
module tb_mmu_cpl_demux;

  logic       aclk = 1'b0;
  logic       areset;
  logic       s_mux_valid;
  logic       s_mux_ready;
  logic [1:0] s_mux_vfid;
  logic [5:0] s_mux_pid;
  logic [3:0] s_mux_dest;
  logic       s_mux_last;
  logic       s_dma_done;
  logic [3:0] m_done_valid;
  logic [3:0] m_done_ready;
  logic [5:0] m_done_pid;
  logic [3:0] m_done_dest;
  logic       cpl_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  mmu_cpl_demux dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_mux_valid  (s_mux_valid),
    .s_mux_ready  (s_mux_ready),
    .s_mux_vfid   (s_mux_vfid),
    .s_mux_pid    (s_mux_pid),
    .s_mux_dest   (s_mux_dest),
    .s_mux_last   (s_mux_last),
    .s_dma_done   (s_dma_done),
    .m_done_valid (m_done_valid),
    .m_done_ready (m_done_ready),
    .m_done_pid   (m_done_pid),
    .m_done_dest  (m_done_dest),
    .cpl_err      (cpl_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [1:0] v, input logic [5:0] p, input logic [3:0] d,
                      input logic l);
    s_mux_valid = 1'b1;
    s_mux_vfid  = v;
    s_mux_pid   = p;
    s_mux_dest  = d;
    s_mux_last  = l;
    step();
    s_mux_valid = 1'b0;
  endtask

  task automatic pulse();
    s_dma_done = 1'b1;
    step();
    s_dma_done = 1'b0;
  endtask

  initial begin
    int acks;
    areset       = 1'b1;
    s_mux_valid  = 1'b0;
    s_mux_vfid   = '0;
    s_mux_pid    = '0;
    s_mux_dest   = '0;
    s_mux_last   = 1'b0;
    s_dma_done   = 1'b0;
    m_done_ready = '0;
    step();
    step();
    check("rst_mux_ready", 32'(s_mux_ready), 0);
    areset = 1'b0;
    #1;
    check("rst_valid", 32'(m_done_valid), 0);
    check("rst_pid", 32'(m_done_pid), 0);
    check("rst_dest", 32'(m_done_dest), 0);
    check("rst_cpl_err", 32'(cpl_err), 0);
    check("rst_mux_ready_after", 32'(s_mux_ready), 1);

    // Single acked request on lane 2.
    push(2'd2, 6'd5, 4'd1, 1'b1);
    pulse();
    check("t1_cnt_after_pulse", 32'(dut.done_cnt_q), 1);
    check("t1_valid_early", 32'(m_done_valid), 0);
    step();
    check("t1_valid", 32'(m_done_valid), 32'h4);
    check("t1_pid", 32'(m_done_pid), 5);
    check("t1_dest", 32'(m_done_dest), 1);
    check("t1_cnt_zero", 32'(dut.done_cnt_q), 0);
    repeat (3) step();
    check("t1_valid_hold", 32'(m_done_valid), 32'h4);
    m_done_ready = 4'b1011;
    step();
    check("t1_other_ready_ignored", 32'(m_done_valid), 32'h4);
    m_done_ready = 4'b0100;
    step();
    m_done_ready = '0;
    check("t1_valid_drop", 32'(m_done_valid), 0);
    check("t1_fifo_empty", 32'(dut.fifo_count), 0);

    // Two silent consumes then one ack on lane 0.
    push(2'd0, 6'd1, 4'd0, 1'b0);
    push(2'd0, 6'd2, 4'd0, 1'b0);
    push(2'd0, 6'd9, 4'd3, 1'b1);
    m_done_ready = 4'b0001;
    s_dma_done = 1'b1;
    repeat (3) step();
    s_dma_done = 1'b0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (m_done_valid != '0) begin
        check("t2_lane", 32'(m_done_valid), 1);
        check("t2_pid", 32'(m_done_pid), 9);
        acks++;
      end
    end
    m_done_ready = '0;
    check("t2_ack_count", 32'(acks), 1);
    check("t2_fifo_empty", 32'(dut.fifo_count), 0);
    check("t2_cnt_zero", 32'(dut.done_cnt_q), 0);

    // Head-of-line: lane 1 stalls, lane 3 must wait.
    push(2'd1, 6'd11, 4'd2, 1'b1);
    push(2'd3, 6'd22, 4'd4, 1'b1);
    pulse();
    pulse();
    for (int i = 0; i < 20; i++) begin
      check("t3_stall_lane1", 32'(m_done_valid), 32'h2);
      step();
    end
    check("t3_cnt_pending", 32'(dut.done_cnt_q), 1);
    check("t3_fifo_one", 32'(dut.fifo_count), 1);
    m_done_ready = 4'b0010;
    step();
    m_done_ready = '0;
    check("t3_gap", 32'(m_done_valid), 0);
    step();
    check("t3_lane3", 32'(m_done_valid), 32'h8);
    check("t3_pid3", 32'(m_done_pid), 22);
    check("t3_dest3", 32'(m_done_dest), 4);
    m_done_ready = 4'b1000;
    step();
    m_done_ready = '0;
    check("t3_done", 32'(m_done_valid), 0);

    // Fill the FIFO to its depth.
    s_mux_valid = 1'b1;
    s_mux_vfid  = 2'd0;
    s_mux_last  = 1'b0;
    repeat (32) step();
    check("t4_full_count", 32'(dut.fifo_count), 32);
    check("t4_ready_low", 32'(s_mux_ready), 0);
    step();
    s_mux_valid = 1'b0;
    check("t4_no_33rd", 32'(dut.fifo_count), 32);
    pulse();
    check("t4_ready_still_low", 32'(s_mux_ready), 0);
    step();
    check("t4_ready_back", 32'(s_mux_ready), 1);
    check("t4_count_31", 32'(dut.fifo_count), 31);
    s_dma_done = 1'b1;
    repeat (31) step();
    s_dma_done = 1'b0;
    repeat (2) step();
    check("t4_drained", 32'(dut.fifo_count), 0);
    check("t4_cnt_zero", 32'(dut.done_cnt_q), 0);
    check("t4_no_err", 32'(cpl_err), 0);
    check("t4_no_valid", 32'(m_done_valid), 0);

    // Spurious completion with nothing outstanding.
    pulse();
    check("t5_err_set", 32'(cpl_err), 1);
    check("t5_cnt_zero", 32'(dut.done_cnt_q), 0);
    repeat (2) step();
    check("t5_no_valid", 32'(m_done_valid), 0);
    push(2'd1, 6'd33, 4'd5, 1'b1);
    pulse();
    step();
    check("t5_valid", 32'(m_done_valid), 32'h2);
    check("t5_pid", 32'(m_done_pid), 33);
    check("t5_dest", 32'(m_done_dest), 5);
    check("t5_err_sticky", 32'(cpl_err), 1);
    m_done_ready = 4'b0010;
    step();
    m_done_ready = '0;
    check("t5_done", 32'(m_done_valid), 0);

    // Reset while sending with three entries still queued.
    for (int i = 0; i < 4; i++) push(2'd2, 6'(40 + i), 4'(i), 1'b1);
    pulse();
    step();
    check("t6_sending", 32'(m_done_valid), 32'h4);
    check("t6_queued", 32'(dut.fifo_count), 3);
    areset = 1'b1;
    #1;
    check("t6_ready_in_reset", 32'(s_mux_ready), 0);
    step();
    areset = 1'b0;
    #1;
    check("t6_valid", 32'(m_done_valid), 0);
    check("t6_fifo", 32'(dut.fifo_count), 0);
    check("t6_cnt", 32'(dut.done_cnt_q), 0);
    check("t6_err", 32'(cpl_err), 0);
    check("t6_pid", 32'(m_done_pid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmu_cpl_demux.md
Name: mmu_cpl_demux

Overview:
Return path for the host-DMA arbiter. The arbiter serialises per-region host DMA requests onto one XDMA channel and pushes one ordering entry per issued request. This block queues those entries, counts XDMA completion pulses, and routes each completion back, in order, to the originating region as a done/ack handshake. One instance per direction (rd, wr) sits between the XDMA host channel and the per-region config slaves.

Parameters:
N_REGIONS, 4, number of dynamic regions (per-region output lanes)
N_REGIONS_BITS, 2, clog2(N_REGIONS), minimum 1
PID_BITS, 6, process ID width
DEST_BITS, 4, destination field width
ORD_DEPTH, 32, ordering FIFO depth (power of 2, at least 4)

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
s_mux_valid  in  1  ordering entry valid
s_mux_ready  out  1  ordering entry accepted
s_mux_vfid  in  N_REGIONS_BITS  originating region
s_mux_pid  in  PID_BITS  process ID
s_mux_dest  in  DEST_BITS  destination
s_mux_last  in  1  1 = final chunk of a user request (generates ack)
s_dma_done  in  1  single-cycle XDMA completion pulse, no backpressure
m_done_valid  out  N_REGIONS  per-region ack valid (one-hot or zero)
m_done_ready  in  N_REGIONS  per-region ack ready
m_done_pid  out  PID_BITS  ack process ID (shared by all lanes)
m_done_dest  out  DEST_BITS  ack destination (shared)
cpl_err  out  1  sticky: done pulse arrived with no outstanding entry

Behaviour:
- Interface fixed: one clock, aclk. Reset areset is synchronous and active-high.
- Reset: FIFO empty, done_cnt=0, FSM=IDLE, m_done_valid=0, m_done_pid/dest=0, cpl_err=0. s_mux_ready is 0 while areset is high. Entries and pulses arriving mid-operation are discarded at reset.
- Ordering FIFO: depth ORD_DEPTH, entry = {vfid, pid, dest, last}.
  - s_mux_ready = !full. A push is allowed only when !full, even if a pop happens in the same cycle.
  - Pointers wrap modulo ORD_DEPTH. Occupancy counter width is clog2(ORD_DEPTH)+1.
- done_cnt (clog2(ORD_DEPTH)+1 bits) counts completion pulses not yet consumed.
  - Pulse with no pop in the same cycle: +1.
  - Pop with no pulse: -1.
  - Pulse and pop in the same cycle: unchanged.
  - Pulse when done_cnt equals FIFO occupancy (no unmatched entry): pulse dropped, cpl_err set. cpl_err clears only on reset.
- FSM:
  - IDLE: if done_cnt>0 and FIFO not empty, pop the head.
    - head.last=1: load pid/dest/vfid into the output register, go to SEND.
    - head.last=0: silent consume, stay in IDLE.
  - SEND: m_done_valid[vfid]=1 and all other lanes 0. On m_done_ready[vfid]=1, go to IDLE.
  - pid and dest stay stable while valid is high. Ready on non-selected lanes is ignored.
- Latency: pulse sampled at cycle N → done_cnt updated at N+1 → pop at N+1 → m_done_valid high at N+2. Minimum 3 cycles per acked completion (IDLE→SEND→IDLE). One pop per cycle for last=0 entries.
- Ordering: acks leave strictly in push order. A stalled region lane blocks all later completions (head-of-line). Pulses keep accumulating in done_cnt meanwhile.
- No combinational path from s_dma_done or m_done_ready to any output.

Decomposition:
- Shared package: the ordering entry typedef {vfid, pid, dest, last}, defined as the same struct the arbiter drives.
- Sub-module mmu_ord_fifo: a sync FIFO with full, empty and occupancy outputs. Every other piece is top-level logic.

Test Plan:
- Push {vfid=2, pid=5, dest=1, last=1}, then pulse done once. Required: m_done_valid=4'b0100 at pulse+2 with pid=5 and dest=1, held until ready[2]; done_cnt returns to 0.
- Push {vfid=0, last=0}, {vfid=0, last=0}, {vfid=0, pid=9, last=1}, then 3 consecutive pulses. Required: exactly one ack on lane 0 with pid=9, FIFO empty afterwards.
- Push entries for vfid 1 then vfid 3, hold ready[1]=0 for 20 cycles, pulse twice. Required: lane 3 stays silent until lane 1 is acked; then lane 3 ack follows, in order.
- Fill FIFO with 32 entries. Required: s_mux_ready=0 and a 33rd push is not taken. A pulse pops one entry; ready rises the next cycle.
- Pulse done with FIFO empty. Required: cpl_err=1 and no valid raised; a later push+pulse still acks normally, with cpl_err staying 1.
- Assert areset during SEND with 3 queued entries. Required: all valids 0, FIFO empty, done_cnt=0, cpl_err=0 on the next cycle.
